// File: rtl/audio_frame_buffer_if.sv
// Sample-stream, FFT handshake and frame-readout bundle for audio_frame_buffer.
interface audio_frame_buffer_if #(
  parameter int WIDTH     = 12,
  parameter int N         = 64,
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_sample;
  logic [WIDTH-1:0]     time_samples [0:N-1];
  logic                 fft_rst;
  logic                 fft_start;
  logic                 fft_done;
  logic [CNT_WIDTH-1:0] frame_count;
  logic                 overrun;
  logic                 overrun_clr;

  modport master (
    output in_valid, in_sample, fft_done, overrun_clr,
    input  in_ready, time_samples, fft_rst, fft_start, frame_count, overrun
  );

  modport slave (
    input  in_valid, in_sample, fft_done, overrun_clr,
    output in_ready, time_samples, fft_rst, fft_start, frame_count, overrun
  );
endinterface

// File: rtl/audio_frame_buffer.sv
// Ping-pong frame collector feeding the FFT: fills one bank while the other is
// presented on time_samples, then sequences the FFT reset/start handshake.
module audio_frame_buffer #(
  parameter int WIDTH         = 12,
  parameter int N             = 64,
  parameter int OFFSET_BINARY = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  audio_frame_buffer_if.slave   bus
);
  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  typedef enum logic [1:0] {FILL, HOLD, KICK_RST, KICK_START} state_t;

  state_t               state_q;
  logic                 wbank_q;
  logic [PW-1:0]        wptr_q;
  logic                 busy_q;
  logic                 in_ready_q;
  logic                 fft_rst_q;
  logic                 fft_start_q;
  logic [CNT_WIDTH-1:0] frame_count_q;
  logic                 overrun_q;
  logic                 overrun_d;
  logic [WIDTH-1:0]     sample_d;
  logic [WIDTH-1:0]     bank_q [2][N];
  logic                 accept;

  assign accept = bus.in_valid && in_ready_q;

  always_comb begin
    sample_d = bus.in_sample;
    if (OFFSET_BINARY != 0) sample_d[WIDTH-1] = ~bus.in_sample[WIDTH-1];
  end

  // Set wins over a simultaneous clear.
  always_comb begin
    overrun_d = overrun_q;
    if (bus.overrun_clr) overrun_d = 1'b0;
    if (bus.in_valid && !in_ready_q) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned i = 0; i < N; i++)
          bank_q[b][i] <= '0;
    end else if (accept) begin
      bank_q[wbank_q][wptr_q] <= sample_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      wbank_q       <= 1'b0;
      wptr_q        <= '0;
      busy_q        <= 1'b0;
      in_ready_q    <= 1'b1;
      fft_rst_q     <= 1'b0;
      fft_start_q   <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      fft_rst_q   <= 1'b0;
      fft_start_q <= 1'b0;
      overrun_q   <= overrun_d;
      if (busy_q && bus.fft_done && state_q != KICK_START) busy_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (accept) begin
            wptr_q <= wptr_q + 1'b1;
            if (wptr_q == LAST) begin
              in_ready_q <= 1'b0;
              if (!busy_q) begin
                state_q   <= KICK_RST;
                fft_rst_q <= 1'b1;
              end else begin
                state_q <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (!busy_q) begin
            state_q   <= KICK_RST;
            fft_rst_q <= 1'b1;
          end
        end
        KICK_RST: begin
          wbank_q       <= ~wbank_q;
          wptr_q        <= '0;
          frame_count_q <= frame_count_q + 1'b1;
          fft_start_q   <= 1'b1;
          state_q       <= KICK_START;
        end
        KICK_START: begin
          busy_q     <= 1'b1;
          in_ready_q <= 1'b1;
          state_q    <= FILL;
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.fft_rst     = fft_rst_q;
  assign bus.fft_start   = fft_start_q;
  assign bus.frame_count = frame_count_q;
  assign bus.overrun     = overrun_q;

  always_comb begin
    for (int unsigned i = 0; i < N; i++)
      bus.time_samples[i] = bank_q[~wbank_q][i];
  end
endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed/randomized bench for audio_frame_buffer against a frame-level model.
module tb_audio_frame_buffer;
  localparam int W = 12;
  localparam int N = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  audio_frame_buffer_if #(.WIDTH(W), .N(N), .CNT_WIDTH(16)) bus ();

  audio_frame_buffer #(
    .WIDTH(W), .N(N), .OFFSET_BINARY(1), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial forever #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] exp_ts [N];
  logic [W-1:0] cur [$];
  logic [15:0]  exp_count;
  bit           exp_ovr;

  function automatic logic [W-1:0] conv(input logic [W-1:0] x);
    return x ^ 12'h800;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(bus.time_samples[i]), 32'(exp_ts[i]));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(bus.in_ready), 1);
    chk({tag, "_fft_rst"}, 32'(bus.fft_rst), 0);
    chk({tag, "_fft_start"}, 32'(bus.fft_start), 0);
    chk({tag, "_count"}, 32'(bus.frame_count), 0);
    chk({tag, "_overrun"}, 32'(bus.overrun), 0);
    chk_frame({tag, "_ts"});
  endtask

  // Offers one frame; gap idle cycles follow every sample except the last.
  task automatic feed(input logic [W-1:0] vals [N], input int gap);
    for (int i = 0; i < N; i++) begin
      int waited = 0;
      while (!bus.in_ready && waited < 50) begin
        tick();
        waited++;
      end
      if (!bus.in_ready) begin
        chk("in_ready_timeout", 0, 1);
        bus.in_valid = 1'b0;
        return;
      end
      bus.in_valid  = 1'b1;
      bus.in_sample = vals[i];
      tick();
      cur.push_back(conv(vals[i]));
      if (gap > 0 && i != N - 1) begin
        bus.in_valid = 1'b0;
        repeat (gap) tick();
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Called in the cycle where fft_rst is expected high.
  task automatic kick_seq(input bit ovr_exp);
    chk("kick_fft_rst", 32'(bus.fft_rst), 1);
    chk("kick_no_start", 32'(bus.fft_start), 0);
    chk("kick_ready_low", 32'(bus.in_ready), 0);
    chk("kick_count_old", 32'(bus.frame_count), 32'(exp_count));
    chk_frame("pre_swap");
    bus.fft_done = 1'b0;
    tick();
    bus.in_valid    = 1'b0;
    bus.overrun_clr = 1'b0;
    for (int i = 0; i < N; i++) exp_ts[i] = (i < cur.size()) ? cur[i] : '0;
    cur.delete();
    exp_count = 16'(exp_count + 1);
    chk("start_fft_rst", 32'(bus.fft_rst), 0);
    chk("start_pulse", 32'(bus.fft_start), 1);
    chk("start_ready_low", 32'(bus.in_ready), 0);
    chk("start_count", 32'(bus.frame_count), 32'(exp_count));
    chk("start_overrun", 32'(bus.overrun), 32'(ovr_exp));
    chk_frame("post_swap");
    tick();
    chk("refill_start_low", 32'(bus.fft_start), 0);
    chk("refill_rst_low", 32'(bus.fft_rst), 0);
    chk("refill_ready", 32'(bus.in_ready), 1);
  endtask

  initial begin
    logic [W-1:0] vals [N];
    int n;

    bus.in_valid    = 1'b0;
    bus.in_sample   = '0;
    bus.fft_done    = 1'b0;
    bus.overrun_clr = 1'b0;
    for (int i = 0; i < N; i++) exp_ts[i] = '0;
    exp_count = '0;
    exp_ovr   = 1'b0;

    // Reset held, then released and idle
    repeat (3) tick();
    chk_reset_state("rst");
    rst_n = 1'b1;
    repeat (10) tick();
    chk_reset_state("idle");

    // Frame 1: ramp, FFT idle
    for (int i = 0; i < N; i++) vals[i] = W'(i * 64);
    feed(vals, 0);
    kick_seq(1'b0);
    chk("f1_ts0", 32'(bus.time_samples[0]), 32'h800);
    chk("f1_ts32", 32'(bus.time_samples[32]), 32'h000);
    chk("f1_ts63", 32'(bus.time_samples[63]), 32'h7C0);

    // Frame 2: FFT still busy -> HOLD with backpressure
    for (int i = 0; i < N; i++) vals[i] = W'($urandom);
    feed(vals, 0);
    chk("hold_ready_low", 32'(bus.in_ready), 0);
    chk("hold_no_rst", 32'(bus.fft_rst), 0);
    bus.in_valid  = 1'b1;
    bus.in_sample = W'($urandom);
    repeat (3) tick();
    bus.in_valid = 1'b0;
    exp_ovr = 1'b1;
    chk("hold_overrun", 32'(bus.overrun), 1);
    chk("hold_no_rst2", 32'(bus.fft_rst), 0);
    chk_frame("hold_ts");
    bus.fft_done = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.fft_rst && n < 6);
    chk("hold_release_le2", 32'(n <= 2), 1);
    kick_seq(1'b1);

    // overrun_clr with no offer clears the flag
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    exp_ovr = 1'b0;
    chk("ovr_clr", 32'(bus.overrun), 0);

    // Frame 3: gapped pattern, FFT finishes while filling
    bus.fft_done = 1'b1;
    for (int i = 0; i < N; i++)
      vals[i] = (i % 3 == 0) ? 12'hFFF : (i % 3 == 1) ? 12'h000 : 12'h800;
    feed(vals, 2);
    kick_seq(1'b0);
    chk("gap_ts0", 32'(bus.time_samples[0]), 32'h7FF);
    chk("gap_ts1", 32'(bus.time_samples[1]), 32'h800);
    chk("gap_ts2", 32'(bus.time_samples[2]), 32'h000);
    chk("gap_no_overrun", 32'(bus.overrun), 0);

    // Frame 4: offer plus clear during KICK_RST -> overrun stays set
    bus.fft_done = 1'b1;
    for (int i = 0; i < N; i++) vals[i] = W'($urandom);
    feed(vals, 0);
    bus.in_valid    = 1'b1;
    bus.in_sample   = W'($urandom);
    bus.overrun_clr = 1'b1;
    kick_seq(1'b1);
    chk("clr_vs_set", 32'(bus.overrun), 1);

    // Asynchronous reset in the middle of a fill
    for (int i = 0; i < 30; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_sample = W'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    cur.delete();
    for (int i = 0; i < N; i++) exp_ts[i] = '0;
    exp_count = '0;
    chk_reset_state("async");
    #1 rst_n = 1'b1;
    tick();
    bus.fft_done = 1'b0;
    for (int i = 0; i < N; i++) vals[i] = W'($urandom);
    feed(vals, 0);
    kick_seq(1'b0);
    chk("post_rst_ts0", 32'(bus.time_samples[0]), 32'(conv(vals[0])));
    chk("post_rst_count", 32'(bus.frame_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/audio_frame_buffer.md
Name: audio_frame_buffer

Overview:
- Upstream feeder for the 64-point radix-4 FFT block.
- Collects a continuous stream of ADC audio samples into N-sample frames using ping-pong (double-buffered) register banks.
- Converts offset-binary ADC codes to two's complement.
- Presents the completed frame on a parallel array and sequences the FFT's synchronous-reset/start handshake, so capture of the next frame overlaps FFT computation.

Parameters:
- WIDTH, 12, sample width in bits; must match the FFT WIDTH.
- N, 64, samples per frame; must match the FFT N; power of 2.
- OFFSET_BINARY, 1, 1: invert the MSB of each input sample (offset-binary to two's complement); 0: store the sample unchanged.
- CNT_WIDTH, 16, width of frame_count.

Ports:
- clk, input, 1, system clock; all logic on posedge.
- rst_n, input, 1, reset; one clock; asynchronous, active-low.
- in_valid, input, 1, in_sample valid this cycle.
- in_ready, output, 1, block can accept a sample this cycle.
- in_sample, input, WIDTH, raw ADC sample.
- time_samples, output, WIDTH x [0:N-1], read-bank contents; drives the FFT time_samples.
- fft_rst, output, 1, one-cycle synchronous active-high reset pulse to the FFT.
- fft_start, output, 1, one-cycle start pulse to the FFT.
- fft_done, input, 1, FFT done level (high while the FFT is in its DONE state).
- frame_count, output, CNT_WIDTH, number of frames handed to the FFT.
- overrun, output, 1, sticky flag: a sample was offered while in_ready was low.
- overrun_clr, input, 1, synchronous clear of overrun.

Behaviour:
- Storage: two banks of N x WIDTH registers. wbank selects the bank being filled; the read bank is ~wbank. time_samples is combinationally the read bank.
- Reset (rst_n low, asynchronous):
  - Both banks cleared to 0, so time_samples are all 0.
  - wbank=0, wptr=0, state=FILL, busy=0.
  - Outputs: in_ready=1, fft_rst=0, fft_start=0, frame_count=0, overrun=0.
  - Reset asserted mid-frame discards the partial frame and aborts the handshake.
- Accept rule: a sample is taken on the posedge where in_valid && in_ready. Bank[wbank][wptr] <= OFFSET_BINARY ? {~in_sample[WIDTH-1], in_sample[WIDTH-2:0]} : in_sample, then wptr increments. Gaps in in_valid are allowed and do not affect ordering.
- States:
  - FILL: in_ready=1. On accepting the sample at wptr==N-1: go to KICK_RST if busy==0, otherwise go to HOLD.
  - HOLD: in_ready=0. The write bank is full and the FFT is still busy. Go to KICK_RST on the cycle after busy is observed 0.
  - KICK_RST:
    - in_ready=0, fft_rst=1.
    - At the end of the cycle: wbank<=~wbank (the completed frame becomes the read bank), wptr<=0, frame_count<=frame_count+1 (wraps at all-ones to 0).
    - Next state: KICK_START.
  - KICK_START: in_ready=0, fft_start=1, busy<=1. Next state: FILL.
- Busy tracking: busy clears on any posedge where busy==1, fft_done==1, and state is not KICK_START. The fft_done from a previous run is removed by the fft_rst pulse before start, so a stale done is never counted.
- Latency: if the final sample of a frame is accepted at edge t (FFT idle):
  - fft_rst is high in cycle t+1.
  - time_samples shows the new frame from edge t+1.
  - fft_start is high in cycle t+2.
  - in_ready is high again in cycle t+3.
- Stability: time_samples changes only at the KICK_RST edge, never while busy.
- Overrun:
  - Set on any edge with in_valid && !in_ready. The sample is dropped and wptr is unchanged.
  - overrun_clr clears overrun. Simultaneous set and clear leaves overrun set.
  - The 2-cycle kick gap per frame counts as overrun if the source does not honour in_ready.
- fft_rst and fft_start are never high in the same cycle. Each is high for exactly one cycle per frame.

Test Plan:
- Reset: hold rst_n=0 while clk runs -> in_ready=1, fft_rst=fft_start=0, frame_count=0, overrun=0, all time_samples=0; release and idle 10 cycles -> nothing changes.
- First frame (OFFSET_BINARY=1): feed in_sample=i*64 for i=0..63 back-to-back, fft_done=0 -> fft_rst one cycle after the 64th accept, fft_start the next cycle; time_samples[i]=(i*64)^12'h800 (e.g. [0]=12'h800, [32]=12'h000, [63]=12'h7C0); frame_count=1; in_ready high 3 cycles after the last accept.
- Overlap/backpressure: after frame 1 keep fft_done=0, fill frame 2 -> enters HOLD with in_ready=0 and time_samples still equal to frame 1; hold in_valid high -> overrun=1; raise fft_done -> fft_rst within 2 cycles, time_samples switches to frame 2, frame_count=2.
- Gapped input: valid asserted every 3rd cycle with values 0xFFF, 0x000, 0x800 repeating -> stored values 0x7FF, 0x800, 0x000 in order; no overrun.
- Async reset mid-fill: drop rst_n between clock edges after 30 samples -> outputs return to reset values immediately; a following full frame lands at index 0 and frame_count=1.
- overrun_clr: with overrun=1, pulse overrun_clr with in_valid=0 -> overrun=0; pulse overrun_clr with in_valid=1 during KICK_RST -> overrun stays 1.
